// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the SPI command scheduler:
// scheduler states, command framing and command field helpers.
package spi_cmd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WAIT,
      SEND,
      BUSY,
      GAP
   } state_t;

   // A command is four bytes, MSB first: {count[15:0], value[15:0]}
   localparam int CMD_BYTES = 4;
   localparam int COUNT_MSB = 31;
   localparam int COUNT_LSB = 16;
   localparam int VALUE_MSB = 15;
   localparam int VALUE_LSB = 0;

   function automatic logic [15:0] cmd_count(input logic [31:0] cmd);
      return cmd[COUNT_MSB:COUNT_LSB];
   endfunction

   function automatic logic [15:0] cmd_value(input logic [31:0] cmd);
      return cmd[VALUE_MSB:VALUE_LSB];
   endfunction

endpackage

// File: rtl/spi_cmd_scheduler_if.sv
// Bus bundle between the scheduler, its two rx fifos and the spiword driver.
// master = scheduler side, slave = fifos / driver / system side.
interface spi_cmd_scheduler_if;

   logic        src0_empty;
   logic [7:0]  src0_data;
   logic        src0_read;
   logic        src1_empty;
   logic [7:0]  src1_data;
   logic        src1_read;
   logic        spi_running;
   logic        spi_we;
   logic [15:0] spi_word;
   logic        csn;
   logic [1:0]  grant;
   logic        busy;
   logic [1:0]  err_timeout;

   modport master (
      input  src0_empty, src0_data, src1_empty, src1_data, spi_running,
      output src0_read, src1_read, spi_we, spi_word, csn, grant, busy, err_timeout
   );

   modport slave (
      output src0_empty, src0_data, src1_empty, src1_data, spi_running,
      input  src0_read, src1_read, spi_we, spi_word, csn, grant, busy, err_timeout
   );

endinterface

// File: rtl/spi_cmd_scheduler_cmd_assembler.sv
// Byte-to-command assembler for one first-word-fall-through fifo.
// Holds a finished command until the scheduler accepts it, and drops
// a partial command when its source goes quiet for too long.
module cmd_assembler
   import spi_cmd_pkg::*;
#(
   parameter int BYTE_TIMEOUT = 40000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        empty,
   input  logic [7:0]  data,
   input  logic        accept,
   output logic        read,
   output logic        cmd_valid,
   output logic [31:0] cmd,
   output logic        err_timeout
);

   localparam int TW = $clog2(BYTE_TIMEOUT + 1);

   logic [1:0]    cnt_reg;
   logic          valid_reg;
   logic [31:0]   cmd_reg;
   logic [TW-1:0] idle_reg;
   logic          err_reg;

   // A pending command blocks further pops unless it is being accepted this cycle
   assign read        = !empty && (!valid_reg || accept);
   assign cmd_valid   = valid_reg;
   assign cmd         = cmd_reg;
   assign err_timeout = err_reg;

   // Shift bytes in, flag the 4th byte, and time out stalled partial commands
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_reg   <= '0;
         valid_reg <= 1'b0;
         cmd_reg   <= '0;
         idle_reg  <= '0;
         err_reg   <= 1'b0;
      end else begin
         err_reg <= 1'b0;
         if (accept) begin
            valid_reg <= 1'b0;
         end
         if (read) begin
            cmd_reg  <= {cmd_reg[23:0], data};
            idle_reg <= '0;
            if (cnt_reg == 2'(CMD_BYTES - 1)) begin
               cnt_reg   <= '0;
               valid_reg <= 1'b1;
            end else begin
               cnt_reg <= cnt_reg + 2'd1;
            end
         end else if (cnt_reg != 2'd0) begin
            if (idle_reg == TW'(BYTE_TIMEOUT - 1)) begin
               cnt_reg  <= '0;
               idle_reg <= '0;
               err_reg  <= 1'b1;
            end else begin
               idle_reg <= idle_reg + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/spi_cmd_scheduler.sv
// Two-source SPI command scheduler: round-robin arbitration between the
// UART and SPI-slave command streams, per-command hold-off, then one
// spiword load framed by CSn with a guaranteed inter-frame gap.
module spi_cmd_scheduler
   import spi_cmd_pkg::*;
#(
   parameter int VALUE_SHIFT  = 2,
   parameter int CS_GAP       = 4,
   parameter int BYTE_TIMEOUT = 40000
) (
   input logic                 clk,
   input logic                 reset,
   spi_cmd_scheduler_if.master bus
);

   localparam int GW = $clog2(CS_GAP + 1);

   state_t        state_reg;
   logic          rr_reg;
   logic [1:0]    grant_reg;
   logic [15:0]   timer_reg;
   logic [15:0]   value_reg;
   logic [15:0]   spi_word_reg;
   logic          spi_we_reg;
   logic          csn_reg;
   logic          first_reg;
   logic [GW-1:0] gap_reg;

   logic [1:0]    src_empty;
   logic [1:0]    src_read;
   logic [1:0]    cmd_valid;
   logic [1:0]    accept;
   logic [1:0]    err_pulse;
   logic [7:0]    src_data [2];
   logic [31:0]   cmd [2];
   logic [31:0]   cmd_sel;

   assign src_empty   = {bus.src1_empty, bus.src0_empty};
   assign src_data[0] = bus.src0_data;
   assign src_data[1] = bus.src1_data;

   assign bus.src0_read   = src_read[0];
   assign bus.src1_read   = src_read[1];
   assign bus.err_timeout = err_pulse;
   assign bus.spi_we      = spi_we_reg;
   assign bus.spi_word    = spi_word_reg;
   assign bus.csn         = csn_reg;
   assign bus.grant       = grant_reg;
   assign bus.busy        = (state_reg != IDLE);

   assign cmd_sel = grant_reg[1] ? cmd[1] : cmd[0];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         // The granted source's command is consumed in the LOAD cycle
         assign accept[gi] = (state_reg == LOAD) && grant_reg[gi];

         cmd_assembler #(
            .BYTE_TIMEOUT(BYTE_TIMEOUT)
         ) u_asm (
            .clk        (clk),
            .reset      (reset),
            .empty      (src_empty[gi]),
            .data       (src_data[gi]),
            .accept     (accept[gi]),
            .read       (src_read[gi]),
            .cmd_valid  (cmd_valid[gi]),
            .cmd        (cmd[gi]),
            .err_timeout(err_pulse[gi])
         );
      end
   endgenerate

   // Arbitration, hold-off timer and CSn framing; all outputs registered
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         rr_reg       <= 1'b0;
         grant_reg    <= '0;
         timer_reg    <= '0;
         value_reg    <= '0;
         spi_word_reg <= '0;
         spi_we_reg   <= 1'b0;
         csn_reg      <= 1'b1;
         first_reg    <= 1'b0;
         gap_reg      <= '0;
      end else begin
         spi_we_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               // Never start while the driver is still shifting a previous word
               if ((|cmd_valid) && !bus.spi_running) begin
                  if (&cmd_valid) begin
                     grant_reg <= rr_reg ? 2'b10 : 2'b01;
                     rr_reg    <= ~rr_reg;
                  end else begin
                     grant_reg <= cmd_valid;
                  end
                  state_reg <= LOAD;
               end
            end
            LOAD: begin
               value_reg <= cmd_value(cmd_sel);
               timer_reg <= cmd_count(cmd_sel);
               state_reg <= (cmd_count(cmd_sel) == 16'd0) ? SEND : WAIT;
            end
            WAIT: begin
               // Entered with timer >= 1, so the count of WAIT cycles equals count
               if (timer_reg <= 16'd1) begin
                  timer_reg <= '0;
                  state_reg <= SEND;
               end else begin
                  timer_reg <= timer_reg - 16'd1;
               end
            end
            SEND: begin
               spi_we_reg   <= 1'b1;
               spi_word_reg <= value_reg >> VALUE_SHIFT;
               csn_reg      <= 1'b0;
               first_reg    <= 1'b1;
               state_reg    <= BUSY;
            end
            BUSY: begin
               // First BUSY cycle is the load strobe itself; the driver has not
               // had a chance to raise spi_running yet
               if (first_reg) begin
                  first_reg <= 1'b0;
               end else if (!bus.spi_running) begin
                  csn_reg   <= 1'b1;
                  gap_reg   <= GW'(CS_GAP - 1);
                  state_reg <= GAP;
               end
            end
            GAP: begin
               if (gap_reg == '0) begin
                  grant_reg <= '0;
                  state_reg <= IDLE;
               end else begin
                  gap_reg <= gap_reg - 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_cmd_scheduler.sv
// Directed bench for spi_cmd_scheduler: fifo and spiword models, a scoreboard
// of expected words/grants/latencies, and inline checks for each scenario.
module tb_spi_cmd_scheduler;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   spi_cmd_scheduler_if ifc();

   spi_cmd_scheduler #(
      .VALUE_SHIFT (2),
      .CS_GAP      (4),
      .BYTE_TIMEOUT(40000)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (ifc)
   );

   typedef struct {
      logic [15:0] word;
      logic [1:0]  grant;
      int          lat;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] q0[$];
   logic [7:0] q1[$];

   int checks = 0;
   int passed = 0;
   int cycle = 0;
   int t_grant = 0;
   int we_count = 0;
   int pops0 = 0;
   int pops1 = 0;
   int high_run = 0;
   int err_cnt0 = 0;
   int err_cnt1 = 0;
   int run_cnt = 0;
   logic [1:0] grant_prev = 2'b00;
   logic [1:0] pend = 2'b00;
   logic csn_prev = 1'b1;
   logic run_prev = 1'b0;
   logic had_frame = 1'b0;
   logic run_model = 1'b0;
   logic run_force = 1'b0;

   assign ifc.spi_running = run_model | run_force;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
   endtask

   // Fifo and spiword models: update just after each rising edge
   initial begin
      ifc.src0_empty = 1'b1;
      ifc.src0_data  = 8'h00;
      ifc.src1_empty = 1'b1;
      ifc.src1_data  = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         if (pend[0] && q0.size() > 0) begin
            q0.delete(0);
            pops0++;
         end
         if (pend[1] && q1.size() > 0) begin
            q1.delete(0);
            pops1++;
         end
         ifc.src0_empty = (q0.size() == 0);
         ifc.src0_data  = (q0.size() > 0) ? q0[0] : 8'h00;
         ifc.src1_empty = (q1.size() == 0);
         ifc.src1_data  = (q1.size() > 0) ? q1[0] : 8'h00;
         if (ifc.spi_we === 1'b1) begin
            run_model = 1'b1;
            run_cnt   = 6;
         end else if (run_cnt > 0) begin
            run_cnt--;
            if (run_cnt == 0) run_model = 1'b0;
         end
      end
   end

   // Monitor: scoreboard pops on each load strobe, CSn framing checks
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         cycle++;
         pend = reset ? 2'b00 : {ifc.src1_read, ifc.src0_read};
         if (ifc.err_timeout[0] === 1'b1) err_cnt0++;
         if (ifc.err_timeout[1] === 1'b1) err_cnt1++;
         if (grant_prev == 2'b00 && ifc.grant != 2'b00) t_grant = cycle;
         grant_prev = ifc.grant;
         if (ifc.spi_we === 1'b1) begin
            we_count++;
            if (exp_q.size() == 0) begin
               check("spi_we_expected", exp_q.size(), 1);
            end else begin
               e = exp_q.pop_front();
               $display("load strobe: word=0x%04h grant=%b latency=%0d", ifc.spi_word, ifc.grant, cycle - t_grant);
               check("spi_word", {16'h0, ifc.spi_word}, {16'h0, e.word});
               check("grant", {30'h0, ifc.grant}, {30'h0, e.grant});
               check("latency", 32'(cycle - t_grant), 32'(e.lat));
               check("csn_low_at_we", {31'h0, ifc.csn}, 0);
            end
         end
         if (ifc.csn === 1'b1 && !csn_prev) check("csn_rise_after_running_low", {31'h0, run_prev}, 0);
         if (ifc.csn === 1'b0 && csn_prev && had_frame) check("cs_gap_min", {31'h0, high_run >= 4}, 1);
         if (ifc.csn === 1'b0 && csn_prev) had_frame = 1'b1;
         high_run = (ifc.csn === 1'b1) ? high_run + 1 : 0;
         csn_prev = ifc.csn;
         run_prev = ifc.spi_running;
      end
   end

   task automatic push_bytes(input int src, input logic [15:0] cnt, input logic [15:0] val);
      logic [31:0] c;
      c = {cnt, val};
      for (int i = 3; i >= 0; i--) begin
         if (src == 0) q0.push_back(c[i*8 +: 8]);
         else          q1.push_back(c[i*8 +: 8]);
      end
   endtask

   task automatic expect_cmd(input logic [15:0] cnt, input logic [15:0] val, input logic [1:0] g);
      exp_t e;
      e.word  = val >> 2;
      e.grant = g;
      e.lat   = int'(cnt) + 2;
      exp_q.push_back(e);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || ifc.busy !== 1'b0 || ifc.spi_running !== 1'b0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done"}, {31'h0, n < budget}, 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_grant(input string tag, input logic [1:0] g, input int budget);
      int n;
      n = 0;
      while (ifc.grant !== g && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, {31'h0, n < budget}, 1);
   endtask

   initial begin
      int we0;
      int p0;

      // Reset state
      repeat (4) @(negedge clk);
      check("rst_csn", {31'h0, ifc.csn}, 1);
      check("rst_busy", {31'h0, ifc.busy}, 0);
      check("rst_grant", {30'h0, ifc.grant}, 0);
      check("rst_spi_we", {31'h0, ifc.spi_we}, 0);
      check("rst_spi_word", {16'h0, ifc.spi_word}, 0);
      check("rst_err", {30'h0, ifc.err_timeout}, 0);
      check("rst_read", {30'h0, ifc.src1_read, ifc.src0_read}, 0);
      reset = 1'b0;
      @(negedge clk);

      // 1: single command from src0, 3 hold-off cycles
      we0 = we_count;
      push_bytes(0, 16'h0003, 16'h1234);
      expect_cmd(16'h0003, 16'h1234, 2'b01);
      wait_idle("t1", 2000);
      check("t1_we_count", 32'(we_count - we0), 1);
      check("t1_grant_cleared", {30'h0, ifc.grant}, 0);

      // 2: simultaneous sources, round-robin order then alternation
      push_bytes(0, 16'h00BB, 16'h0000);
      push_bytes(1, 16'h0000, 16'h0008);
      expect_cmd(16'h00BB, 16'h0000, 2'b01);
      expect_cmd(16'h0000, 16'h0008, 2'b10);
      wait_idle("t2a", 3000);
      push_bytes(0, 16'h0005, 16'h0010);
      push_bytes(1, 16'h0002, 16'h000C);
      expect_cmd(16'h0002, 16'h000C, 2'b10);
      expect_cmd(16'h0005, 16'h0010, 2'b01);
      wait_idle("t2b", 3000);

      // 3: zero count, full value
      push_bytes(1, 16'h0000, 16'hFFFF);
      expect_cmd(16'h0000, 16'hFFFF, 2'b10);
      wait_idle("t3", 2000);

      // 4: partial command times out, then a fresh command parses cleanly
      we0 = we_count;
      q0.push_back(8'h00);
      q0.push_back(8'h01);
      repeat (39980) @(negedge clk);
      check("t4_no_early_timeout", 32'(err_cnt0), 0);
      repeat (50) @(negedge clk);
      check("t4_timeout_pulse", 32'(err_cnt0), 1);
      check("t4_other_src_quiet", 32'(err_cnt1), 0);
      check("t4_no_spi_we", 32'(we_count - we0), 0);
      push_bytes(0, 16'h0001, 16'h0004);
      expect_cmd(16'h0001, 16'h0004, 2'b01);
      wait_idle("t4", 2000);

      // 5: reset during WAIT with the driver busy; next command waits for it
      we0 = we_count;
      push_bytes(0, 16'h0010, 16'h0040);
      wait_grant("t5_grant", 2'b01, 200);
      repeat (3) @(negedge clk);
      run_force = 1'b1;
      check("t5_busy_in_wait", {31'h0, ifc.busy}, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("t5_csn_after_rst", {31'h0, ifc.csn}, 1);
      check("t5_busy_after_rst", {31'h0, ifc.busy}, 0);
      check("t5_we_after_rst", {31'h0, ifc.spi_we}, 0);
      push_bytes(1, 16'h0000, 16'h0020);
      expect_cmd(16'h0000, 16'h0020, 2'b10);
      repeat (30) @(negedge clk);
      check("t5_held_grant", {30'h0, ifc.grant}, 0);
      check("t5_held_busy", {31'h0, ifc.busy}, 0);
      check("t5_held_we", 32'(we_count - we0), 0);
      run_force = 1'b0;
      wait_idle("t5", 2000);
      check("t5_we_count", 32'(we_count - we0), 1);

      // 6: backpressure on src0 while src1's command sits in WAIT
      push_bytes(1, 16'h0100, 16'h0040);
      expect_cmd(16'h0100, 16'h0040, 2'b10);
      wait_grant("t6_grant1", 2'b10, 200);
      p0 = pops0;
      push_bytes(0, 16'h0000, 16'h0080);
      push_bytes(0, 16'h0000, 16'h00C0);
      expect_cmd(16'h0000, 16'h0080, 2'b01);
      expect_cmd(16'h0000, 16'h00C0, 2'b01);
      repeat (60) @(negedge clk);
      check("t6_pops_stalled", 32'(pops0 - p0), 4);
      check("t6_read_low", {31'h0, ifc.src0_read}, 0);
      check("t6_busy", {31'h0, ifc.busy}, 1);
      wait_grant("t6_grant0", 2'b01, 1000);
      check("t6_read_at_load", {31'h0, ifc.src0_read}, 1);
      wait_idle("t6", 3000);
      check("t6_pops_total", 32'(pops0 - p0), 8);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
